mm_seq_ctrl: RTL and testbench

Sequencer for the matrix-multiply datapath. It accepts DIM rows of A and DIM rows of B from the host over a valid/ready stream and steers them into the A skew-FIFO memory and the B memory. It then enables memA, memB and the systolic array for the fixed compute window, and streams the DIM result rows of C out with backpressure. It sits between the host/testbench row interface and the memA / memB / systolic-array instances.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_seq_ctrl_if.sv | 21 ++
 rtl/mm_phase_cnt.sv | 40 ++++
 rtl/mm_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mm_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared types and sizing for the matrix-multiply sequencer, memA, memB and
// the systolic array, so every block agrees on DIM-derived constants.
package mm_pkg;

  localparam int unsigned DIM = 8;

  function automatic int unsigned compute_cycles(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

  localparam int unsigned COMPUTE_CYCLES = compute_cycles(DIM);
  localparam int unsigned CNT_W          = $clog2(3 * DIM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_COMPUTE,
    ST_READ_C,
    ST_DONE
  } mm_state_t;

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// Host-side control and stream handshakes of the matrix-multiply sequencer.
// Row data itself bypasses the sequencer; only the handshakes live here.
interface mm_seq_ctrl_if;
  logic start;
  logic in_valid;
  logic in_ready;
  logic c_valid;
  logic c_ready;
  logic busy;
  logic done;

  modport master (
    output start, in_valid, c_ready,
    input  in_ready, c_valid, busy, done
  );

  modport slave (
    input  start, in_valid, c_ready,
    output in_ready, c_valid, busy, done
  );
endinterface

// File: rtl/mm_phase_cnt.sv
// Phase counter shared by every sequencer phase: synchronous clear has
// priority over increment, and tc_o flags an exact match with term_i.
module mm_phase_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step on increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/mm_seq_ctrl.sv
// Matrix-multiply sequencer: loads DIM rows of A then B from the host,
// runs the fixed compute window, then streams DIM rows of C with backpressure.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned DIM   = mm_pkg::DIM,
  parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  mm_seq_ctrl_if.slave           host,
  output logic                   memA_en,
  output logic                   memA_WrEn,
  output logic [$clog2(DIM)-1:0] memA_Arow,
  output logic                   memB_en,
  output logic                   sa_en,
  output logic [$clog2(DIM)-1:0] sa_Crow
);

  localparam int unsigned AW = $clog2(DIM);
  localparam logic [CNT_W-1:0] TERM_ROW = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] TERM_CMP = CNT_W'(compute_cycles(DIM) - 1);

  mm_state_t        state_q;
  mm_state_t        state_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  mm_phase_cnt #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // State register; reset returns to IDLE from any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode from (state, cnt, in_valid, c_ready).
  // The counter is cleared on every state change, so each phase starts at 0.
  always_comb begin
    state_d       = state_q;
    cnt_inc       = 1'b0;
    cnt_term      = TERM_ROW;
    host.in_ready = 1'b0;
    host.c_valid  = 1'b0;
    host.busy     = 1'b1;
    host.done     = 1'b0;
    memA_en       = 1'b0;
    memA_WrEn     = 1'b0;
    memA_Arow     = '0;
    memB_en       = 1'b0;
    sa_en         = 1'b0;
    sa_Crow       = '0;

    unique case (state_q)
      ST_IDLE: begin
        host.busy = 1'b0;
        if (host.start) begin
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        host.in_ready = 1'b1;
        memA_WrEn     = host.in_valid;
        memA_Arow     = AW'(cnt);
        cnt_inc       = host.in_valid;
        if (host.in_valid && cnt_tc) begin
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        host.in_ready = 1'b1;
        memB_en       = host.in_valid;
        cnt_inc       = host.in_valid;
        if (host.in_valid && cnt_tc) begin
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        memA_en  = 1'b1;
        memB_en  = 1'b1;
        sa_en    = 1'b1;
        cnt_inc  = 1'b1;
        cnt_term = TERM_CMP;
        if (cnt_tc) begin
          state_d = ST_READ_C;
        end
      end
      ST_READ_C: begin
        host.c_valid = 1'b1;
        sa_Crow      = AW'(cnt);
        cnt_inc      = host.c_ready;
        if (host.c_ready && cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        host.done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        host.busy = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    cnt_clr = (state_d != state_q);
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: expected memA rows and C rows are queued
// when a sequence is launched and popped as the DUT handshakes them.
module tb_mm_seq_ctrl;
  import mm_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          memA_en;
  logic          memA_WrEn;
  logic [AW-1:0] memA_Arow;
  logic          memB_en;
  logic          sa_en;
  logic [AW-1:0] sa_Crow;

  mm_seq_ctrl_if hif ();

  mm_seq_ctrl #(
    .DIM   (D),
    .CNT_W ($clog2(3 * D))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif),
    .memA_en   (memA_en),
    .memA_WrEn (memA_WrEn),
    .memA_Arow (memA_Arow),
    .memB_en   (memB_en),
    .sa_en     (sa_en),
    .sa_Crow   (sa_Crow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int qA[$];
  int qC[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One quiet cycle: every output must be 0 outside a sequence.
  task automatic idle_cycle(input string nm);
    hif.start    = 1'b0;
    hif.in_valid = 1'b1;
    hif.c_ready  = 1'b1;
    @(negedge clk);
    check({nm, "/idle_busy"},     hif.busy,     0);
    check({nm, "/idle_done"},     hif.done,     0);
    check({nm, "/idle_in_ready"}, hif.in_ready, 0);
    check({nm, "/idle_c_valid"},  hif.c_valid,  0);
    check({nm, "/idle_sa_en"},    sa_en,        0);
    check({nm, "/idle_memA_en"},  memA_en,      0);
    check({nm, "/idle_memB_en"},  memB_en,      0);
    check({nm, "/idle_wren"},     memA_WrEn,    0);
    next_cycle();
  endtask

  // Launch one multiply from IDLE; *_row is the handshake count at which a
  // stall of *_len cycles is inserted. Returns right after the done cycle.
  task automatic run_seq(input string nm,
                         input int a_row, input int a_len,
                         input int b_row, input int b_len,
                         input int c_row, input int c_len,
                         input bit spurious, input bit b2b,
                         input int exp_cycles);
    int hsA = 0;
    int hsB = 0;
    int hsC = 0;
    int saN = 0;
    int bN  = 0;
    int bad = 0;
    int k   = 0;
    int a_rem = a_len;
    int b_rem = b_len;
    int c_rem = c_len;
    bit got_done = 1'b0;

    for (int r = 0; r < int'(D); r++) begin
      qA.push_back(r);
      qC.push_back(r);
    end

    while (!got_done && k < 200) begin
      hif.start    = (k == 0);
      hif.in_valid = 1'b1;
      hif.c_ready  = 1'b1;
      if (hif.in_ready) begin
        if (hsA < int'(D)) begin
          if (hsA == a_row && a_rem > 0) begin
            hif.in_valid = 1'b0;
            a_rem--;
          end
        end else begin
          if (hsB == b_row && b_rem > 0) begin
            hif.in_valid = 1'b0;
            b_rem--;
          end
          if (spurious) hif.start = 1'b1;
        end
      end
      if (hif.c_valid) begin
        if (hsC == c_row && c_rem > 0) begin
          hif.c_ready = 1'b0;
          c_rem--;
        end
        if (spurious) hif.start = 1'b1;
      end
      if (b2b && hif.done) hif.start = 1'b1;

      @(negedge clk);
      if (k == 0) check({nm, "/start_cycle_idle"}, hif.busy, 0);
      if (k == 1) begin
        check({nm, "/first_load_ready"}, hif.in_ready, 1);
        check({nm, "/first_arow"}, memA_Arow, 0);
      end
      if (hif.in_ready && !hif.in_valid && hsA < int'(D) && qA.size() > 0) begin
        check({nm, "/stall_wren"}, memA_WrEn, 0);
        check({nm, "/stall_arow"}, memA_Arow, qA[0]);
      end
      if (memA_WrEn) begin
        if (qA.size() > 0) begin
          check({nm, "/arow"}, memA_Arow, qA.pop_front());
        end else begin
          fail_cnt++;
          $error("FAIL %s/arow_extra: observed write of row %0d expected none", nm, memA_Arow);
        end
        hsA++;
      end
      if (memB_en && !sa_en) begin
        bN++;
        hsB++;
      end
      if (sa_en) begin
        saN++;
        if (hif.in_ready || memA_WrEn) bad++;
      end
      if (hif.c_valid && !hif.c_ready && qC.size() > 0)
        check({nm, "/crow_hold"}, sa_Crow, qC[0]);
      if (hif.c_valid && hif.c_ready) begin
        if (qC.size() > 0) begin
          check({nm, "/crow"}, sa_Crow, qC.pop_front());
        end else begin
          fail_cnt++;
          $error("FAIL %s/crow_extra: observed row %0d expected none", nm, sa_Crow);
        end
        hsC++;
      end
      if (hif.done) got_done = 1'b1;
      k++;
      next_cycle();
    end

    hif.start = 1'b0;
    check({nm, "/done_seen"},        got_done,   1);
    check({nm, "/start_to_done"},    k,          exp_cycles);
    check({nm, "/sa_en_cycles"},     saN,        3 * D - 2);
    check({nm, "/memB_load_cycles"}, bN,         D);
    check({nm, "/a_rows"},           hsA,        D);
    check({nm, "/c_rows"},           hsC,        D);
    check({nm, "/compute_leak"},     bad,        0);
    check({nm, "/a_left"},           qA.size(),  0);
    check({nm, "/c_left"},           qC.size(),  0);
    qA.delete();
    qC.delete();
  endtask

  initial begin
    int saN;
    int k;

    rst          = 1'b1;
    hif.start    = 1'b0;
    hif.in_valid = 1'b0;
    hif.c_ready  = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset/busy",    hif.busy,     0);
    check("reset/ready",   hif.in_ready, 0);
    check("reset/c_valid", hif.c_valid,  0);
    check("reset/sa_en",   sa_en,        0);
    next_cycle();
    rst = 1'b0;
    idle_cycle("post_reset");

    run_seq("nominal", -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 6 * D);
    idle_cycle("nominal");

    run_seq("load_stall", 4, 3, 5, 2, -1, 0, 1'b0, 1'b0, 6 * D + 5);
    idle_cycle("load_stall");

    run_seq("c_backpressure", -1, 0, -1, 0, 2, 4, 1'b0, 1'b0, 6 * D + 4);
    idle_cycle("c_backpressure");

    run_seq("spurious", -1, 0, -1, 0, -1, 0, 1'b1, 1'b0, 6 * D);
    idle_cycle("spurious");

    // Reset while COMPUTE has cnt=5, with start also high to show priority.
    hif.start    = 1'b1;
    hif.in_valid = 1'b1;
    hif.c_ready  = 1'b1;
    saN = 0;
    k   = 0;
    while (saN < 5 && k < 100) begin
      @(negedge clk);
      if (sa_en) saN++;
      k++;
      next_cycle();
      hif.start = 1'b0;
    end
    check("mid_reset/reached_compute", saN, 5);
    rst       = 1'b1;
    hif.start = 1'b1;
    next_cycle();
    rst       = 1'b0;
    hif.start = 1'b0;
    @(negedge clk);
    check("mid_reset/busy",    hif.busy, 0);
    check("mid_reset/sa_en",   sa_en,    0);
    check("mid_reset/memA_en", memA_en,  0);
    next_cycle();
    run_seq("after_reset", -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 6 * D);
    idle_cycle("after_reset");

    run_seq("b2b_first", -1, 0, -1, 0, -1, 0, 1'b0, 1'b1, 6 * D);
    run_seq("b2b_second", -1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 6 * D);
    idle_cycle("b2b_second");

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
